// File: rtl/gcd_job_scheduler.sv
// gcd_job_scheduler
// Front end for one HLS-generated gcd core that has no start/done handshake.
// Two requesters compete for the core; the winner's operands are loaded onto
// core_a/core_b and a job is launched by pulsing the core's active-low reset.
// After a fixed run budget the core output is captured and handed back to the
// requester through a valid/ready response channel tagged with its index.
module gcd_job_scheduler #(
    parameter int WIDTH      = 32,
    parameter int RST_CYCLES = 2,
    parameter int RUN_CYCLES = 256
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_val,
    output logic             busy,
    output logic             core_rst_n,
    output logic [WIDTH-1:0] core_a,
    output logic [WIDTH-1:0] core_b,
    input  logic [WIDTH-1:0] core_ret
);

    // One counter serves both the reset pulse and the run budget, so it is
    // sized for the longer of the two.
    localparam int CNT_MAX = (RST_CYCLES > RUN_CYCLES) ? RST_CYCLES : RUN_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_CYCLES - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LAUNCH = 2'd1;
    localparam logic [1:0] RUN    = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             last_grant;
    logic             grant;
    logic             accept;
    logic             launch_done;
    logic             run_done;
    logic             resp_done;
    logic [WIDTH-1:0] grant_a;
    logic [WIDTH-1:0] grant_b;

    // Round-robin pick: a lone requester wins outright, a tie goes to the one
    // that was not served last time.
    always_comb begin
        grant = ~last_grant;
        if (req0_valid && !req1_valid) begin
            grant = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            grant = 1'b1;
        end
    end

    assign req0_ready  = (state == IDLE) && !grant;
    assign req1_ready  = (state == IDLE) && grant;
    assign accept      = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign grant_a     = grant ? req1_a : req0_a;
    assign grant_b     = grant ? req1_b : req0_b;
    assign launch_done = (state == LAUNCH) && (cnt == RST_LAST);
    assign run_done    = (state == RUN) && (cnt == RUN_LAST);
    assign resp_done   = (state == RESP) && resp_ready;
    assign busy        = (state != IDLE);

    // Job sequencing: idle -> core reset pulse -> run budget -> response hold.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= LAUNCH;
                        cnt   <= '0;
                    end
                end
                LAUNCH: begin
                    if (launch_done) begin
                        state <= RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (run_done) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (resp_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Remember who was served so the next tie goes the other way.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant;
        end
    end

    // Core control: operands latched only at accept, reset held low through
    // the launch window and released otherwise so the core free-runs.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            core_rst_n <= 1'b0;
            core_a     <= '0;
            core_b     <= '0;
        end else if (accept) begin
            core_rst_n <= 1'b0;
            core_a     <= grant_a;
            core_b     <= grant_b;
        end else if (state == IDLE || launch_done) begin
            core_rst_n <= 1'b1;
        end
    end

    // Response channel: capture the core result at the end of the run budget
    // and hold it until the consumer takes it.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            resp_valid <= 1'b0;
            resp_val   <= '0;
            resp_id    <= 1'b0;
        end else begin
            if (accept) begin
                resp_id <= grant;
            end
            if (run_done) begin
                resp_val   <= core_ret;
                resp_valid <= 1'b1;
            end else if (resp_done) begin
                resp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gcd_job_scheduler.sv
// tb_gcd_job_scheduler
// Bench for gcd_job_scheduler: a stand-in gcd core whose result only becomes
// correct after the worst-case latency, a transaction-level reference model
// that checks every cycle, table-driven single jobs and hand-written
// sequences for arbitration, back-pressure, mid-job reset and operand hold.
module tb_gcd_job_scheduler;

    localparam int W    = 32;
    localparam int RSTC = 2;
    localparam int RUNC = 256;
    localparam int LAT  = RSTC + RUNC;

    logic          sys_clk;
    logic          sys_rst_n;
    logic          req0_valid;
    logic          req0_ready;
    logic [W-1:0]  req0_a;
    logic [W-1:0]  req0_b;
    logic          req1_valid;
    logic          req1_ready;
    logic [W-1:0]  req1_a;
    logic [W-1:0]  req1_b;
    logic          resp_valid;
    logic          resp_ready;
    logic          resp_id;
    logic [W-1:0]  resp_val;
    logic          busy;
    logic          core_rst_n;
    logic [W-1:0]  core_a;
    logic [W-1:0]  core_b;
    logic [W-1:0]  core_ret;

    int checks   = 0;
    int failures = 0;

    gcd_job_scheduler #(
        .WIDTH      (W),
        .RST_CYCLES (RSTC),
        .RUN_CYCLES (RUNC)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_val   (resp_val),
        .busy       (busy),
        .core_rst_n (core_rst_n),
        .core_a     (core_a),
        .core_b     (core_b),
        .core_ret   (core_ret)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Stand-in core: output is garbage until it has been out of reset for
    // RUNC-1 cycles, which is exactly the point the scheduler must sample.
    int core_cnt = 0;
    always @(posedge sys_clk) begin
        if (!core_rst_n) core_cnt <= 0;
        else             core_cnt <= core_cnt + 1;
    end
    assign core_ret = (core_cnt >= RUNC - 1) ? gcd_ref(core_a, core_b) : 32'hBAD0_BAD0;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic report_timeout(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s actual=timeout expected=event", name);
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                                  input logic v1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                                  input logic rr);
        req0_valid = v0;
        req0_a     = a0;
        req0_b     = b0;
        req1_valid = v1;
        req1_a     = a1;
        req1_b     = b1;
        resp_ready = rr;
    endtask

    // Reference model: jobs as transactions with absolute cycle deadlines.
    int           cyc = 0;
    bit           m_known = 0;
    bit           m_busy = 0;
    bit           m_last = 1;
    bit           m_fresh = 0;
    int           m_accept_cyc = 0;
    int           m_resp_cyc = 0;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    logic [W-1:0] m_val = '0;
    bit           m_id = 0;
    int           resp_count = 0;

    // Every mid-cycle, compare all outputs with the model, then advance it.
    always @(negedge sys_clk) begin
        bit g;
        bit exp_rv;
        bit exp_crst;
        cyc++;
        if (req0_valid && !req1_valid)      g = 0;
        else if (req1_valid && !req0_valid) g = 1;
        else                                g = !m_last;
        exp_rv = m_busy && (cyc >= m_resp_cyc);
        if (m_known) begin
            check_output("mon_busy", busy, m_busy);
            check_output("mon_req0_ready", req0_ready, !m_busy && !g);
            check_output("mon_req1_ready", req1_ready, !m_busy && g);
            check_output("mon_resp_valid", resp_valid, exp_rv);
            if (exp_rv) begin
                check_output("mon_resp_val", resp_val, m_val);
                check_output("mon_resp_id", resp_id, m_id);
            end
            exp_crst = m_fresh ? 1'b0 : !(m_busy && cyc <= m_accept_cyc + RSTC);
            check_output("mon_core_rst_n", core_rst_n, exp_crst);
            if (m_busy) begin
                check_output("mon_core_a", core_a, m_a);
                check_output("mon_core_b", core_b, m_b);
            end
        end
        if (!sys_rst_n) begin
            m_known = 1;
            m_busy  = 0;
            m_last  = 1;
            m_fresh = 1;
        end else if (m_known) begin
            m_fresh = 0;
            if (!m_busy) begin
                if ((g == 0 && req0_valid) || (g == 1 && req1_valid)) begin
                    m_busy       = 1;
                    m_last       = g;
                    m_id         = g;
                    m_a          = g ? req1_a : req0_a;
                    m_b          = g ? req1_b : req0_b;
                    m_val        = gcd_ref(m_a, m_b);
                    m_accept_cyc = cyc;
                    m_resp_cyc   = cyc + LAT + 1;
                end
            end else if (exp_rv && resp_ready) begin
                m_busy = 0;
                resp_count++;
            end
        end
    end

    task automatic wait_accept(output int which, input int limit);
        which = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge sys_clk);
            if (req0_valid && req0_ready)      which = 0;
            else if (req1_valid && req1_ready) which = 1;
            tick();
            if (which >= 0) break;
        end
        if (which < 0) report_timeout("accept_wait");
    endtask

    // Call right after the accept edge; lat is edges from accept to resp_valid.
    task automatic wait_resp(output logic [W-1:0] val, output logic id, output int lat, input int limit);
        int  n;
        int  first;
        bit  got;
        n     = 0;
        first = -1;
        got   = 0;
        val   = '0;
        id    = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge sys_clk);
            n++;
            if (resp_valid && first < 0) first = n;
            if (resp_valid && resp_ready) begin
                val = resp_val;
                id  = resp_id;
                got = 1;
            end
            tick();
            if (got) break;
        end
        lat = first - 1;
        if (!got) report_timeout("resp_wait");
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        tick();
        tick();
        sys_rst_n = 1'b1;
    endtask

    typedef struct {
        bit           id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_val;
    } vec_t;

    vec_t         vecs[8];
    int           which;
    int           lat;
    int           low;
    int           seen;
    int           done_before;
    logic [W-1:0] val;
    logic         rid;

    initial begin
        vecs[0] = '{0, 32'd28,         32'd42,         32'd14};
        vecs[1] = '{1, 32'd48,         32'd18,         32'd6};
        vecs[2] = '{0, 32'd17,         32'd5,          32'd1};
        vecs[3] = '{1, 32'd100,        32'd75,         32'd25};
        vecs[4] = '{0, 32'd1024,       32'd96,         32'd32};
        vecs[5] = '{1, 32'd0,          32'd7,          32'd7};
        vecs[6] = '{0, 32'd13,         32'd13,         32'd13};
        vecs[7] = '{1, 32'hFFFF_FFFF,  32'h0000_FFFF,  32'h0000_FFFF};

        apply_stimulus(0, '0, '0, 0, '0, '0, 1);
        do_reset();

        // Reset state; with no requester valid the tie-break favours req0.
        @(negedge sys_clk);
        check_output("rst_resp_valid", resp_valid, 0);
        check_output("rst_resp_val", resp_val, 0);
        check_output("rst_resp_id", resp_id, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_core_rst_n", core_rst_n, 0);
        check_output("rst_core_a", core_a, 0);
        check_output("rst_core_b", core_b, 0);
        check_output("rst_req0_ready", req0_ready, 1);
        check_output("rst_req1_ready", req1_ready, 0);
        tick();

        // Single jobs from the table; operands scrambled after accept.
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].id) apply_stimulus(0, '0, '0, 1, vecs[i].a, vecs[i].b, 1);
            else            apply_stimulus(1, vecs[i].a, vecs[i].b, 0, '0, '0, 1);
            wait_accept(which, 20);
            check_output("vec_grant", which, vecs[i].id);
            apply_stimulus(0, $urandom, $urandom, 0, $urandom, $urandom, 1);
            wait_resp(val, rid, lat, LAT + 20);
            check_output("vec_val", val, vecs[i].exp_val);
            check_output("vec_id", rid, vecs[i].id);
            check_output("vec_latency", lat, LAT);
        end

        // Simultaneous requests right after reset: req0 first, req1 waits.
        do_reset();
        apply_stimulus(1, 32'd48, 32'd18, 1, 32'd17, 32'd5, 1);
        wait_accept(which, 20);
        check_output("t2_first_grant", which, 0);
        req0_valid = 1'b0;
        wait_resp(val, rid, lat, LAT + 20);
        check_output("t2_first_val", val, 6);
        check_output("t2_first_id", rid, 0);
        wait_accept(which, 20);
        check_output("t2_second_grant", which, 1);
        req1_valid = 1'b0;
        wait_resp(val, rid, lat, LAT + 20);
        check_output("t2_second_val", val, 1);
        check_output("t2_second_id", rid, 1);

        // Both requesters held valid: grants must alternate.
        do_reset();
        apply_stimulus(1, 32'd28, 32'd42, 1, 32'd48, 32'd18, 1);
        for (int k = 0; k < 4; k++) begin
            wait_accept(which, 20);
            check_output("t3_grant", which, k % 2);
            wait_resp(val, rid, lat, LAT + 20);
            check_output("t3_id", rid, k % 2);
            check_output("t3_val", val, (k % 2) ? 32'd6 : 32'd14);
        end

        // Back-pressure: response must hold while the consumer stalls.
        apply_stimulus(1, 32'd84, 32'd36, 1, 32'd56, 32'd21, 0);
        wait_accept(which, 20);
        check_output("t4_grant", which, 0);
        seen = 0;
        for (int i = 0; i < LAT + 10; i++) begin
            @(negedge sys_clk);
            if (resp_valid) seen = 1;
            tick();
            if (seen) break;
        end
        if (!seen) report_timeout("t4_resp_valid");
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            check_output("t4_hold_valid", resp_valid, 1);
            check_output("t4_hold_val", resp_val, 12);
            check_output("t4_hold_id", resp_id, 0);
            check_output("t4_req0_ready", req0_ready, 0);
            check_output("t4_req1_ready", req1_ready, 0);
            check_output("t4_busy", busy, 1);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        wait_accept(which, 20);
        check_output("t4_next_grant", which, 1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_resp(val, rid, lat, LAT + 20);
        check_output("t4_next_val", val, 7);
        check_output("t4_next_id", rid, 1);

        // Reset in the middle of a run aborts the job with no response.
        apply_stimulus(1, 32'd100, 32'd75, 0, '0, '0, 1);
        wait_accept(which, 20);
        req0_valid = 1'b0;
        for (int i = 0; i < RSTC + 50; i++) tick();
        sys_rst_n = 1'b0;
        tick();
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check_output("t5_resp_valid", resp_valid, 0);
        check_output("t5_core_rst_n", core_rst_n, 0);
        check_output("t5_busy", busy, 0);
        tick();
        seen = 0;
        for (int i = 0; i < LAT + 10; i++) begin
            @(negedge sys_clk);
            if (resp_valid) seen++;
            tick();
        end
        check_output("t5_no_stale_resp", seen, 0);
        apply_stimulus(1, 32'd28, 32'd42, 0, '0, '0, 1);
        wait_accept(which, 20);
        req0_valid = 1'b0;
        wait_resp(val, rid, lat, LAT + 20);
        check_output("t5_new_val", val, 14);
        check_output("t5_new_id", rid, 0);

        // Reset pulse width and operand hold while inputs toggle.
        apply_stimulus(1, 32'd1071, 32'd462, 0, '0, '0, 1);
        wait_accept(which, 20);
        req0_valid = 1'b0;
        low = 0;
        for (int i = 0; i < RSTC + 4; i++) begin
            req0_a = $urandom;
            req0_b = $urandom;
            @(negedge sys_clk);
            if (!core_rst_n) low++;
            check_output("t6_core_a", core_a, 1071);
            check_output("t6_core_b", core_b, 462);
            tick();
        end
        check_output("t6_pulse_width", low, RSTC);
        wait_resp(val, rid, lat, LAT + 20);
        check_output("t6_val", val, 21);

        // Random traffic against the reference model.
        apply_stimulus(0, '0, '0, 0, '0, '0, 1);
        do_reset();
        done_before = resp_count;
        for (int i = 0; i < 6000; i++) begin
            int k0;
            int k1;
            k0 = $urandom_range(1, 50);
            k1 = $urandom_range(1, 50);
            sys_rst_n  = ($urandom_range(0, 2999) != 0);
            req0_valid = ($urandom_range(0, 99) < 60);
            req1_valid = ($urandom_range(0, 99) < 60);
            req0_a     = W'($urandom_range(0, 500) * k0);
            req0_b     = W'($urandom_range(1, 500) * k0);
            req1_a     = W'($urandom_range(1, 500) * k1);
            req1_b     = W'($urandom_range(0, 500) * k1);
            resp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        sys_rst_n = 1'b1;
        check_output("random_progress", resp_count > done_before + 5, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
